// File: rtl/xgmii_pkg.sv
// XGMII character constants, fixed control words and framer state encoding.
package xgmii_pkg;

  localparam logic [7:0] XGMII_IDLE  = 8'h07;
  localparam logic [7:0] XGMII_START = 8'hFB;
  localparam logic [7:0] XGMII_TERM  = 8'hFD;
  localparam logic [7:0] XGMII_ERR   = 8'hFE;

  localparam logic [63:0] IDLE_WORD     = {8{XGMII_IDLE}};
  localparam logic [63:0] ERROR_WORD    = {8{XGMII_ERR}};
  localparam logic [63:0] PREAMBLE_WORD = 64'hD5555555555555FB;

  typedef enum logic [1:0] {IDLE, DATA, DROP, IFG} state_t;

  // Valid byte count of a closing word; only meaningful for masks other than 8'hFF.
  function automatic logic [2:0] trailing_ones(input logic [7:0] mask);
    logic [2:0] k;
    logic       stop;
    k    = '0;
    stop = 1'b0;
    for (int i = 0; i < 8; i++) begin
      if (!stop && mask[i]) k = k + 3'd1;
      else stop = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/xgmii_term_encoder.sv
// Builds the terminate word: k data lanes, FD in lane k, idles above it.
module xgmii_term_encoder
  import xgmii_pkg::*;
(
  input  logic [63:0] data,
  input  logic [2:0]  k,
  output logic [63:0] txd,
  output logic [7:0]  txc
);

  always_comb begin
    txd = IDLE_WORD;
    txc = 8'hFF;
    for (int i = 0; i < 8; i++) begin
      if (i < int'(k)) begin
        txd[8*i +: 8] = data[8*i +: 8];
        txc[i]        = 1'b0;
      end else if (i == int'(k)) begin
        txd[8*i +: 8] = XGMII_TERM;
      end
    end
  end

endmodule

// File: rtl/xgmii_tx_framer.sv
// Drains frame words from an FWFT FIFO and frames them onto one XGMII TX lane group.
// state | meaning
// IDLE  | idles out; drops stray delimiters, starts a frame when data and link are present
// DATA  | forwards payload words until the closing word, or aborts with an error word
// DROP  | idles out; discards the rest of an aborted frame up to its closing word
// IFG   | IFG_CYCLES idle words after a frame
module xgmii_tx_framer
  import xgmii_pkg::*;
#(
  parameter int IFG_CYCLES = 2
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [71:0] dout,
  input  logic        empty,
  output logic        rd_en,
  input  logic        link_up,
  output logic [63:0] xgmii_txd,
  output logic [7:0]  xgmii_txc,
  output logic [31:0] tx_frames,
  output logic [15:0] tx_underruns,
  output logic        busy
);

  localparam int CW = (IFG_CYCLES > 1) ? $clog2(IFG_CYCLES) : 1;
  localparam logic [CW-1:0] IFG_LOAD = CW'(IFG_CYCLES - 1);

  state_t        state;
  logic [CW-1:0] ifg_cnt;
  logic [7:0]    mask;
  logic [63:0]   word;
  logic [2:0]    k;
  logic [63:0]   term_txd;
  logic [7:0]    term_txc;

  assign mask = dout[71:64];
  assign word = dout[63:0];
  assign k    = trailing_ones(mask);
  assign busy = (state != IDLE);

  xgmii_term_encoder u_term (
    .data (word),
    .k    (k),
    .txd  (term_txd),
    .txc  (term_txc)
  );

  always_comb begin
    rd_en = 1'b0;
    if (sys_rst && !empty) begin
      case (state)
        IDLE:    rd_en = (mask == 8'h00);
        DATA:    rd_en = link_up;
        DROP:    rd_en = 1'b1;
        default: rd_en = 1'b0;
      endcase
    end
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      state        <= IDLE;
      ifg_cnt      <= '0;
      xgmii_txd    <= IDLE_WORD;
      xgmii_txc    <= 8'hFF;
      tx_frames    <= '0;
      tx_underruns <= '0;
    end else begin
      xgmii_txd <= IDLE_WORD;
      xgmii_txc <= 8'hFF;
      case (state)
        IDLE: begin
          if (!empty && mask != 8'h00 && link_up) begin
            xgmii_txd <= PREAMBLE_WORD;
            xgmii_txc <= 8'h01;
            state     <= DATA;
          end
        end
        DATA: begin
          if (empty || !link_up) begin
            xgmii_txd <= ERROR_WORD;
            if (tx_underruns != 16'hFFFF) tx_underruns <= tx_underruns + 16'd1;
            state <= DROP;
          end else if (mask == 8'hFF) begin
            xgmii_txd <= word;
            xgmii_txc <= 8'h00;
          end else begin
            xgmii_txd <= term_txd;
            xgmii_txc <= term_txc;
            tx_frames <= tx_frames + 32'd1;
            ifg_cnt   <= IFG_LOAD;
            state     <= IFG;
          end
        end
        DROP: begin
          if (!empty && mask != 8'hFF) begin
            ifg_cnt <= IFG_LOAD;
            state   <= IFG;
          end
        end
        default: begin
          if (ifg_cnt == '0) state <= IDLE;
          else ifg_cnt <= ifg_cnt - 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_xgmii_tx_framer.sv
// Randomized bench: FIFO model feeds the framer, a frame-level model predicts the XGMII word stream.
module tb_xgmii_tx_framer;

  localparam int IFG = 2;
  localparam logic [71:0] IDLE_W = {8'hFF, 64'h0707070707070707};
  localparam logic [71:0] PRE_W  = {8'h01, 64'hD5555555555555FB};
  localparam logic [71:0] ERR_W  = {8'hFF, 64'hFEFEFEFEFEFEFEFE};

  logic        sys_clk, sys_rst, empty, rd_en, link_up, busy;
  logic [71:0] dout;
  logic [63:0] xgmii_txd;
  logic [7:0]  xgmii_txc;
  logic [31:0] tx_frames;
  logic [15:0] tx_underruns;

  logic [71:0] fifo_q[$], obs_q[$], exp_q[$], frame_q[$], frame_exp[$];
  int n_chk = 0, n_pass = 0, viol = 0, n_fr = 0, n_un = 0;
  bit mon_en = 0;

  xgmii_tx_framer #(.IFG_CYCLES(IFG)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .dout(dout), .empty(empty), .rd_en(rd_en),
    .link_up(link_up), .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc),
    .tx_frames(tx_frames), .tx_underruns(tx_underruns), .busy(busy)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, expv);
  endtask

  task automatic refresh();
    empty = (fifo_q.size() == 0);
    dout  = empty ? {8'($urandom), 32'($urandom), 32'($urandom)} : fifo_q[0];
  endtask

  // One clock: pop decision sampled mid-cycle, FIFO and outputs updated just after the edge.
  task automatic cycle();
    logic        pop;
    logic [71:0] tmp;
    @(negedge sys_clk);
    pop = rd_en;
    if (rd_en && (empty || !sys_rst)) viol++;
    @(posedge sys_clk);
    #1;
    if (pop && fifo_q.size() > 0) tmp = fifo_q.pop_front();
    refresh();
    if (mon_en) obs_q.push_back({xgmii_txc, xgmii_txd});
  endtask

  task automatic run(input int n);
    repeat (n) cycle();
  endtask

  task automatic drain(input int maxc);
    int c = 0;
    while (fifo_q.size() != 0 && c < maxc) begin
      cycle();
      c++;
    end
    chk("drain_timeout", 72'(fifo_q.size()), 72'd0);
    run(IFG + 6);
  endtask

  // Random frame of len bytes: FIFO words in frame_q, expected XGMII words in frame_exp.
  task automatic gen_frame(input int len, input bit exact_mask);
    logic [7:0]  b[0:127];
    logic [63:0] d, td;
    logic [7:0]  m, lo, tc;
    int full, rem;
    frame_q.delete();
    frame_exp.delete();
    for (int i = 0; i < len; i++) b[i] = 8'($urandom);
    full = len / 8;
    rem  = len % 8;
    frame_exp.push_back(PRE_W);
    for (int w = 0; w < full; w++) begin
      for (int i = 0; i < 8; i++) d[8*i +: 8] = b[8*w + i];
      frame_q.push_back({8'hFF, d});
      frame_exp.push_back({8'h00, d});
    end
    d = {32'($urandom), 32'($urandom)};
    for (int i = 0; i < rem; i++) d[8*i +: 8] = b[8*full + i];
    lo = 8'((1 << rem) - 1);
    if (rem == 0 || exact_mask) m = lo;
    else m = lo | (8'($urandom) & ~8'((2 << rem) - 1));
    frame_q.push_back({m, d});
    for (int i = 0; i < 8; i++) begin
      if (i < rem) begin td[8*i +: 8] = b[8*full + i]; tc[i] = 1'b0; end
      else if (i == rem) begin td[8*i +: 8] = 8'hFD; tc[i] = 1'b1; end
      else begin td[8*i +: 8] = 8'h07; tc[i] = 1'b1; end
    end
    frame_exp.push_back({tc, td});
  endtask

  task automatic push_words(input int from, input int to);
    for (int i = from; i < to; i++) fifo_q.push_back(frame_q[i]);
    refresh();
  endtask

  task automatic push_frame();
    push_words(0, frame_q.size());
    foreach (frame_exp[i]) exp_q.push_back(frame_exp[i]);
    n_fr++;
  endtask

  // Non-idle words must match in order; idle gaps only before a preamble.
  task automatic verify_stream(input bit exact);
    int j = 0, gap = 0;
    bit seen = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i] == IDLE_W) begin
        gap++;
      end else begin
        if (obs_q[i] == PRE_W) begin
          if (seen) begin
            if (exact) chk("ifg_exact", 72'(gap), 72'(IFG));
            else chk("ifg_min", 72'(gap >= IFG), 72'd1);
          end
        end else begin
          chk("bubble", 72'(gap), 72'd0);
        end
        if (j < exp_q.size()) chk("word", obs_q[i], exp_q[j]);
        else chk("extra_word", obs_q[i], IDLE_W);
        j++;
        gap  = 0;
        seen = 1;
      end
    end
    chk("word_count", 72'(j), 72'(exp_q.size()));
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int lens[6];
    int m, c;
    sys_rst = 1'b0;
    link_up = 1'b1;
    refresh();
    run(3);
    chk("reset_out", {xgmii_txc, xgmii_txd}, IDLE_W);
    chk("reset_frames", 72'(tx_frames), 72'd0);
    chk("reset_underruns", 72'(tx_underruns), 72'd0);
    chk("reset_busy", 72'(busy), 72'd0);

    // Back-to-back frames queued before reset release, including 64-, 61- and 60-byte frames.
    lens = '{64, 61, 60, 60, 0, 0};
    lens[4] = $urandom_range(1, 90);
    lens[5] = $urandom_range(1, 90);
    foreach (lens[i]) begin
      gen_frame(lens[i], lens[i] == 61);
      push_frame();
    end
    run(2);
    sys_rst = 1'b1;
    mon_en  = 1'b1;
    run(3);
    chk("busy_data", 72'(busy), 72'd1);
    drain(400);
    chk("latency_pre", obs_q[0], PRE_W);
    chk("latency_data", obs_q[1], exp_q[1]);
    verify_stream(1);
    chk("frames_b2b", 72'(tx_frames), 72'(n_fr));
    chk("busy_idle", 72'(busy), 72'd0);

    // Frames with random spacing and occasional stray delimiters.
    for (int f = 0; f < 6; f++) begin
      if ($urandom_range(0, 3) == 0) begin
        fifo_q.push_back({8'h00, 32'($urandom), 32'($urandom)});
        refresh();
      end
      gen_frame($urandom_range(1, 90), 0);
      push_frame();
      run($urandom_range(0, 12));
    end
    drain(600);
    verify_stream(0);
    chk("frames_gapped", 72'(tx_frames), 72'(n_fr));

    // Underruns: the FIFO runs dry mid-frame, the remainder arrives later.
    for (int u = 0; u < 3; u++) begin
      gen_frame(64 + $urandom_range(1, 7), 0);
      m = $urandom_range(1, 5);
      push_words(0, m);
      for (int i = 0; i <= m; i++) exp_q.push_back(frame_exp[i]);
      exp_q.push_back(ERR_W);
      n_un++;
      c = 0;
      while (fifo_q.size() != 0 && c < 50) begin cycle(); c++; end
      run($urandom_range(3, 6));
      chk("busy_drop", 72'(busy), 72'd1);
      push_words(m, frame_q.size());
      drain(100);
      gen_frame($urandom_range(1, 70), 0);
      push_frame();
      drain(100);
    end
    verify_stream(0);
    chk("underruns", 72'(tx_underruns), 72'(n_un));
    chk("frames_after_underrun", 72'(tx_frames), 72'(n_fr));

    // Link loss mid-frame, then a frame held back while the link is down.
    gen_frame(64 + $urandom_range(0, 20), 0);
    push_words(0, frame_q.size());
    c = $urandom_range(2, 4);
    for (int i = 0; i < c; i++) exp_q.push_back(frame_exp[i]);
    exp_q.push_back(ERR_W);
    n_un++;
    run(c);
    link_up = 1'b0;
    drain(100);
    gen_frame($urandom_range(1, 40), 0);
    push_words(0, frame_q.size());
    run(20);
    chk("link_down_no_pop", 72'(fifo_q.size()), 72'(frame_q.size()));
    verify_stream(0);
    link_up = 1'b1;
    foreach (frame_exp[i]) exp_q.push_back(frame_exp[i]);
    n_fr++;
    drain(100);
    verify_stream(0);
    chk("underruns_link", 72'(tx_underruns), 72'(n_un));
    chk("frames_link", 72'(tx_frames), 72'(n_fr));

    // Reset after two data words of a frame.
    gen_frame(40, 0);
    push_words(0, frame_q.size());
    c = 0;
    while (obs_q.size() < 3 && c < 20) begin cycle(); c++; end
    chk("mid_frame_words", 72'(obs_q.size()), 72'd3);
    sys_rst = 1'b0;
    cycle();
    chk("rst_mid_out", obs_q[obs_q.size()-1], IDLE_W);
    chk("rst_mid_frames", 72'(tx_frames), 72'd0);
    chk("rst_mid_underruns", 72'(tx_underruns), 72'd0);
    chk("rst_mid_busy", 72'(busy), 72'd0);
    chk("rst_mid_rd_en", 72'(rd_en), 72'd0);
    fifo_q.delete();
    refresh();
    sys_rst = 1'b1;
    run(2);

    chk("rd_en_protocol", 72'(viol), 72'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
